tt_um_brs: RTL and testbench
============================

Name: tt_um_brs

Overview:
- Tiny Tapeout user tile implementing a Barrel Rotate/Shift (BRS) unit on an 8-bit operand.
- Operand enters on ui_in; operation and amount enter on uio[5:0].
- Result is registered onto uo_out; status flags are driven on uio[7:6].
- Sits directly under the chip-level Tiny Tapeout wrapper as the top-level user module.

Parameters:
- WIDTH, 8, data width (fixed by the pad ring; not overridable in practice).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  tile enable; high when the design is selected.
- ui_in  input  8  operand A.
- uo_out  output  8  registered result.
- uio_in  input  8  [2:0] op, [5:3] amt; [7:6] ignored.
- uio_out  output  8  [6] zero flag, [7] valid; [5:0] driven 0.
- uio_oe  output  8  constant 8'b1100_0000.
- GL builds also carry VPWR/VGND power pins; these are not used in RTL.

Behaviour:
- Reset: on a clk edge with rst_n=0, uo_out=0x00, zero=0, valid=0. Reset wins over ena and over any op.
- uio_oe and uio_out[5:0] are constant and independent of reset.
- Registers update only when ena=1 (and rst_n=1). With ena=0, all outputs hold.
- Op encoding, with n = amt (0..7); result R is computed from A = ui_in:
  - 000 PASS: R=A.
  - 001 SLL: R=A<<n, zero fill.
  - 010 SRL: R=A>>n, zero fill.
  - 011 SRA: R=A>>>n, sign fill from A[7].
  - 100 ROL: rotate left by n.
  - 101 ROR: rotate right by n.
  - 110 REV: bit reverse, R[i]=A[7-i]; amt ignored.
  - 111 HOLD: uo_out, zero and valid keep their values.
- Latency: exactly one cycle. Inputs sampled at edge k appear on outputs after edge k.
- For a non-HOLD op with ena=1: uo_out<=R; zero<=(R==0); valid<=1.
- For HOLD with ena=1: valid<=0. uo_out and zero are unchanged.
- n=0: every shift and rotate returns A unchanged.
- There is no wrap beyond 7 because amt is only 3 bits.
- Datapath is purely combinational between the input pins and the output registers; no multi-cycle state.

Decomposition:
- Shared package brs_pkg holds:
  - op localparams OP_PASS=3'd0 through OP_HOLD=3'd7;
  - WIDTH=8;
  - UIO_OE_MASK=8'hC0.
- One combinational sub-module, brs_shifter (inputs a[7:0], op[2:0], amt[2:0]; output r[7:0]):
  - implemented as a 3-stage logarithmic barrel (stages of 1, 2, 4);
  - fill-bit selection per op;
  - reverse performed ahead of the stages.
- The top module tt_um_brs holds only the registers, flags and pin mapping.

Test Plan:
- Reset: rst_n=0 for 2 cycles with ui_in=0xFF and op=PASS -> uo_out=0x00, uio_out=0x00, uio_oe=0xC0. Release rst_n, then PASS A=0x5A -> uo_out=0x5A and valid=1 one cycle later.
- Shifts:
  - SLL A=0x01, n=7 -> 0x80.
  - SRL A=0x80, n=3 -> 0x10.
  - SRA A=0x80, n=3 -> 0xF0.
  - SRA A=0x40, n=3 -> 0x08.
  - SLL A=0xFF, n=0 -> 0xFF.
- Rotates and reverse:
  - ROL A=0x81, n=1 -> 0x03.
  - ROR A=0x81, n=1 -> 0xC0.
  - ROL A=0x12, n=4 -> 0x21.
  - REV A=0x01, amt=5 -> 0x80.
- Flags: SLL A=0x80, n=1 -> uo_out=0x00, uio_out[6]=1, uio_out[7]=1. Then HOLD with A=0x33 -> uo_out stays 0x00, zero stays 1, valid drops to 0.
- ena gating: with ena=0, apply PASS A=0x77 for 3 cycles -> outputs unchanged. Raise ena -> 0x77 appears after one edge.
- Reset mid-stream: alternate ops every cycle, then assert rst_n=0 for one cycle -> outputs are 0 on the next edge. Normal operation resumes on the cycle after release.

Source files
------------

// File: rtl/brs_pkg.sv
// Shared constants for the barrel rotate/shift tile.
// Op codes, data width and the bidirectional pin output-enable mask.
package brs_pkg;

  localparam int WIDTH = 8;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_SLL  = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_SRA  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_REV  = 3'd6;
  localparam logic [2:0] OP_HOLD = 3'd7;

  localparam logic [7:0] UIO_OE_MASK = 8'hC0;

endpackage

// File: rtl/brs_shifter.sv
// Combinational 3-stage logarithmic barrel (1, 2, 4).
// Reverse happens ahead of the stages; fill bit chosen per op.
module brs_shifter
  import brs_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       op,
  input  logic [2:0]       amt,
  output logic [WIDTH-1:0] r
);

  // One barrel stage: shift or rotate x by d positions.
  function automatic logic [WIDTH-1:0] stage(
    input logic [WIDTH-1:0] x,
    input int               d,
    input logic             left,
    input logic             rot,
    input logic             fill
  );
    logic [WIDTH-1:0] y;
    int src;
    logic wrap;
    y = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (left) begin
        src  = (j - d + WIDTH) % WIDTH;
        wrap = (j < d);
      end else begin
        src  = (j + d) % WIDTH;
        wrap = (j + d >= WIDTH);
      end
      y[j] = (wrap && !rot) ? fill : x[src];
    end
    return y;
  endfunction

  logic [WIDTH-1:0] s0, s1, s2, s3;
  logic [2:0]       k;
  logic             left, rot, fill;

  // Decode op into direction/rotate/fill and run the stages.
  always_comb begin
    s0   = a;
    k    = 3'd0;
    left = 1'b0;
    rot  = 1'b0;
    fill = 1'b0;
    unique case (op)
      OP_SLL: begin k = amt; left = 1'b1; end
      OP_SRL: begin k = amt; end
      OP_SRA: begin k = amt; fill = a[WIDTH-1]; end
      OP_ROL: begin k = amt; left = 1'b1; rot = 1'b1; end
      OP_ROR: begin k = amt; rot = 1'b1; end
      OP_REV: begin
        for (int i = 0; i < WIDTH; i++)
          s0[i] = a[WIDTH-1-i];
      end
      default: ;
    endcase
    s1 = k[0] ? stage(s0, 1, left, rot, fill) : s0;
    s2 = k[1] ? stage(s1, 2, left, rot, fill) : s1;
    s3 = k[2] ? stage(s2, 4, left, rot, fill) : s2;
    r  = s3;
  end

endmodule

// File: rtl/tt_um_brs.sv
// Tiny Tapeout tile: registered barrel rotate/shift unit.
// Holds result/flag registers and maps them onto the pads.
module tt_um_brs
  import brs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             valid;
  logic [2:0]       op;
  logic [2:0]       amt;
  logic             unused;

  assign op     = uio_in[2:0];
  assign amt    = uio_in[5:3];
  assign unused = &{1'b0, uio_in[7:6]};

  brs_shifter u_shifter (
    .a   (ui_in),
    .op  (op),
    .amt (amt),
    .r   (r)
  );

  // Result and flags; HOLD keeps result/zero and drops valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res   <= '0;
      zero  <= 1'b0;
      valid <= 1'b0;
    end else if (ena) begin
      if (op == OP_HOLD) begin
        valid <= 1'b0;
      end else begin
        res   <= r;
        zero  <= (r == '0);
        valid <= 1'b1;
      end
    end
  end

  assign uo_out  = res;
  assign uio_out = {valid, zero, 6'b0};
  assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_brs.sv
// Directed bench for tt_um_brs with a behavioural model,
// a scoreboard queue and immediate assertions.
module tb_tt_um_brs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic [7:0] flags;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_res   = 8'h00;
  logic       m_zero  = 1'b0;
  logic       m_valid = 1'b0;

  tt_um_brs dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model(
    input logic [7:0] a,
    input logic [2:0] op,
    input logic [2:0] n
  );
    logic [15:0]       t;
    logic signed [7:0] s;
    logic [7:0]        y;
    y = a;
    case (op)
      3'd1: y = a << n;
      3'd2: y = a >> n;
      3'd3: begin s = a; y = s >>> n; end
      3'd4: begin t = {a, a} << n; y = t[15:8]; end
      3'd5: begin t = {a, a} >> n; y = t[7:0]; end
      3'd6: for (int i = 0; i < 8; i++) y[i] = a[7 - i];
      default: y = a;
    endcase
    return y;
  endfunction

  // Drive one cycle, predict, push, wait edge, pop and compare.
  task automatic step(
    input string      tag,
    input logic       rst,
    input logic       en,
    input logic [7:0] a,
    input logic [2:0] op,
    input logic [2:0] n,
    input int         lit
  );
    exp_t e;
    logic [7:0] r;
    rst_n  = rst;
    ena    = en;
    ui_in  = a;
    uio_in = {2'($urandom_range(0, 3)), n, op};
    if (!rst) begin
      m_res = 8'h00; m_zero = 1'b0; m_valid = 1'b0;
    end else if (en) begin
      if (op == 3'd7) begin
        m_valid = 1'b0;
      end else begin
        r = model(a, op, n);
        m_res = r; m_zero = (r == 8'h00); m_valid = 1'b1;
      end
    end
    e.tag   = tag;
    e.res   = m_res;
    e.flags = {m_valid, m_zero, 6'b0};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (uo_out === e.res) else begin
        errors++;
        $error("FAIL %s uo_out: got %h expected %h", e.tag, uo_out, e.res);
      end
      checks++;
      assert (uio_out === e.flags) else begin
        errors++;
        $error("FAIL %s uio_out: got %h expected %h", e.tag, uio_out, e.flags);
      end
      checks++;
      assert (uio_oe === 8'hC0) else begin
        errors++;
        $error("FAIL %s uio_oe: got %h expected c0", e.tag, uio_oe);
      end
      if (lit >= 0) begin
        checks++;
        assert (uo_out === 8'(lit)) else begin
          errors++;
          $error("FAIL %s literal: got %h expected %h", e.tag, uo_out, 8'(lit));
        end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #2;

    step("rst0", 0, 1, 8'hFF, 3'd0, 3'd0, 8'h00);
    step("rst1", 0, 1, 8'hFF, 3'd0, 3'd0, 8'h00);
    step("pass", 1, 1, 8'h5A, 3'd0, 3'd0, 8'h5A);

    step("sll7",  1, 1, 8'h01, 3'd1, 3'd7, 8'h80);
    step("srl3",  1, 1, 8'h80, 3'd2, 3'd3, 8'h10);
    step("sra3n", 1, 1, 8'h80, 3'd3, 3'd3, 8'hF0);
    step("sra3p", 1, 1, 8'h40, 3'd3, 3'd3, 8'h08);
    step("sll0",  1, 1, 8'hFF, 3'd1, 3'd0, 8'hFF);

    step("rol1",  1, 1, 8'h81, 3'd4, 3'd1, 8'h03);
    step("ror1",  1, 1, 8'h81, 3'd5, 3'd1, 8'hC0);
    step("rol4",  1, 1, 8'h12, 3'd4, 3'd4, 8'h21);
    step("rev",   1, 1, 8'h01, 3'd6, 3'd5, 8'h80);
    step("ror0",  1, 1, 8'hA5, 3'd5, 3'd0, 8'hA5);
    step("ror7",  1, 1, 8'h03, 3'd5, 3'd7, 8'h06);

    step("zero",  1, 1, 8'h80, 3'd1, 3'd1, 8'h00);
    step("hold",  1, 1, 8'h33, 3'd7, 3'd2, 8'h00);

    step("ena0a", 1, 0, 8'h77, 3'd0, 3'd0, 8'h00);
    step("ena0b", 1, 0, 8'h77, 3'd0, 3'd0, 8'h00);
    step("ena0c", 1, 0, 8'h77, 3'd0, 3'd0, 8'h00);
    step("ena1",  1, 1, 8'h77, 3'd0, 3'd0, 8'h77);

    for (int i = 0; i < 24; i++)
      step("mix", 1, 1, 8'($urandom), 3'(i % 8), 3'($urandom_range(0, 7)), -1);

    step("midrst", 0, 1, 8'hC3, 3'd4, 3'd2, 8'h00);
    step("resume", 1, 1, 8'hC3, 3'd4, 3'd2, 8'h0F);

    for (int i = 0; i < 16; i++)
      step("rand", 1, 1, 8'($urandom), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
